parity_frame_tx: RTL and testbench

//  Serial even-parity frame transmitter. Directly upstream of the even parity checker.
//  - Accepts a DATA_W-bit word over a valid/ready handshake.
//  - Computes the even parity bit p (XOR of all data bits, so data + p has an even count of ones).
//  - Drives a single-wire frame: start, data LSB first, p, stop. Each bit is held CLKS_PER_BIT cycles.
//  - Also presents the accepted word and p in parallel, so the checker can consume them directly.

---
 rtl/parity_frame_pkg.sv | 19 +
 rtl/parity_frame_tx_bit_timer.sv | 28 ++
 rtl/parity_frame_tx.sv | 155 +++++++++++++++
 tb/tb_parity_frame_tx.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the even-parity serial frame transmitter.
package parity_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic LINE_IDLE = 1'b1;

    // Callers zero-extend their word; the padding zeros do not change the XOR.
    function automatic logic even_par(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/parity_frame_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, pulses tick on the last cycle of each bit.
module bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic          tick,
    output logic [CW-1:0] cnt
);

    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    assign tick = (cnt == LAST);

    // Free-running count, held at zero while clr is asserted and wrapping after LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial even-parity frame transmitter: start, data LSB first, parity, stop bit(s).
// Optional feature macro PTX_ERR_INJECT_EN adds the inj input, which inverts the
// transmitted parity bit of the frame accepted while inj=1.
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int unsigned DATA_W       = 3,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef PTX_ERR_INJECT_EN
    input  logic              inj,
`endif
    output logic              tx,
    output logic [DATA_W-1:0] d_out,
    output logic              p,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_MAX = (DATA_W > STOP_BITS) ? DATA_W : STOP_BITS;
    localparam int unsigned IW      = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;
    localparam int unsigned CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [IW-1:0] DATA_LAST = IW'(DATA_W - 1);
    localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'((CLKS_PER_BIT >= 2) ? CLKS_PER_BIT - 2 : 0);

    state_e            state;
    logic [DATA_W-1:0] shreg;
    logic [IW-1:0]     idx;
    logic              par_bit;
    logic              inj_bit;
    logic              tick;
    logic [CW-1:0]     cnt;
    logic              last_stop_next;

`ifdef PTX_ERR_INJECT_EN
    assign inj_bit = inj;
`else
    assign inj_bit = 1'b0;
`endif

    // Idle holds the timer at zero, so every frame starts on a fresh bit period;
    // all other state changes happen on tick, where the timer wraps anyway.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CW           (CW)
    ) u_bit_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .tick  (tick),
        .cnt   (cnt)
    );

    // Lookahead: true when the coming cycle is the final stop-bit cycle, so done is registered.
    always_comb begin
        last_stop_next = 1'b0;
        if (state == STOP && !tick) begin
            last_stop_next = (idx == STOP_LAST) && (cnt == PRE_LAST);
        end else if (tick && CLKS_PER_BIT == 1) begin
            if (state == PARITY) begin
                last_stop_next = (STOP_BITS == 1);
            end else if (state == STOP) begin
                last_stop_next = (STOP_BITS == 2) && (idx == '0);
            end
        end
    end

    // Frame FSM with registered line, handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx       <= LINE_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d_out    <= '0;
            p        <= 1'b0;
            shreg    <= '0;
            idx      <= '0;
            par_bit  <= 1'b0;
        end else begin
            done <= last_stop_next;
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state    <= START;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        d_out    <= in_data;
                        p        <= even_par(64'(in_data));
                        par_bit  <= even_par(64'(in_data)) ^ inj_bit;
                        shreg    <= in_data;
                        idx      <= '0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state <= DATA;
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx == DATA_LAST) begin
                            state <= PARITY;
                            tx    <= par_bit;
                            idx   <= '0;
                        end else begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + IW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state <= STOP;
                        tx    <= LINE_IDLE;
                        idx   <= '0;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (idx == STOP_LAST) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            idx      <= '0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed self-checking bench for parity_frame_tx at default parameters.
module tb_parity_frame_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_data;
    logic       inj;
    logic       tx;
    logic [2:0] d_out;
    logic       p;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parity_frame_tx dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
`ifdef PTX_ERR_INJECT_EN
        .inj      (inj),
`endif
        .tx       (tx),
        .d_out    (d_out),
        .p        (p),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step negedges until in_ready, bounded; the final check reports a timeout.
    task automatic wait_ready(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (in_ready === 1'b1) break;
            @(negedge clk);
        end
        chk({tag, " ready"}, in_ready, 1);
    endtask

    // Call at a negedge with in_valid=1 and in_ready=1: the next posedge accepts.
    // Checks every cycle of the 24-cycle frame; returns at the negedge of the last cycle.
    task automatic check_frame(input logic [2:0] data, input logic exp_p, input logic exp_ptx,
                               input logic hold, input logic disturb, input string tag);
        logic [5:0] bits;
        int         b;
        bits = {1'b1, exp_ptx, data[2], data[1], data[0], 1'b0};
        @(posedge clk);
        #1;
        if (!hold && !disturb) in_valid = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            @(negedge clk);
            b = (cyc - 1) / 4;
            chk($sformatf("%s tx c%0d", tag, cyc), tx, bits[b]);
            chk($sformatf("%s done c%0d", tag, cyc), done, (cyc == 24));
            chk($sformatf("%s busy c%0d", tag, cyc), busy, 1);
            chk($sformatf("%s rdy c%0d", tag, cyc), in_ready, 0);
            chk($sformatf("%s dout c%0d", tag, cyc), d_out, data);
            chk($sformatf("%s p c%0d", tag, cyc), p, exp_p);
            if (disturb) begin
                in_valid = (cyc % 2 == 0) && (cyc < 24);
                in_data  = ~data;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1. Reset with in_valid high.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 3'b111;
        inj      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst tx", tx, 1);
        chk("rst ready", in_ready, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst dout", d_out, 0);
        chk("rst p", p, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rel ready pre-edge", in_ready, 0);
        @(negedge clk);
        chk("rel ready", in_ready, 1);
        chk("rel busy", busy, 0);
        chk("rel tx", tx, 1);

        // 2. Single frame 3'b001.
        in_data  = 3'b001;
        in_valid = 1'b1;
        check_frame(3'b001, 1'b1, 1'b1, 1'b0, 1'b0, "f001");
        @(negedge clk);
        chk("f001 post busy", busy, 0);
        chk("f001 post ready", in_ready, 1);
        chk("f001 post done", done, 0);
        chk("f001 post tx", tx, 1);

        // 3. Back-to-back 3'b011 then 3'b111 with in_valid held.
        in_data  = 3'b011;
        in_valid = 1'b1;
        check_frame(3'b011, 1'b0, 1'b0, 1'b1, 1'b0, "f011");
        in_data = 3'b111;
        @(negedge clk);
        chk("b2b idle ready", in_ready, 1);
        chk("b2b idle busy", busy, 0);
        check_frame(3'b111, 1'b1, 1'b1, 1'b0, 1'b0, "f111");

        // 4. Reset pulse during DATA bit index 1.
        wait_ready("pre-abort");
        in_data  = 3'b100;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort pre tx", tx, 0);
        chk("abort pre busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort tx", tx, 1);
        chk("abort busy", busy, 0);
        chk("abort ready", in_ready, 0);
        chk("abort dout", d_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ready("post-abort");
        in_data  = 3'b101;
        in_valid = 1'b1;
        check_frame(3'b101, 1'b0, 1'b0, 1'b0, 1'b0, "f101");

        // 5. Toggle in_valid with another word while busy.
        wait_ready("pre-disturb");
        in_data  = 3'b010;
        in_valid = 1'b1;
        check_frame(3'b010, 1'b1, 1'b1, 1'b0, 1'b1, "f010dist");
        @(negedge clk);
        chk("dist post busy", busy, 0);
        chk("dist post dout", d_out, 3'b010);

`ifdef PTX_ERR_INJECT_EN
        // 6. Injected parity error on 3'b110.
        wait_ready("pre-inj");
        in_data  = 3'b110;
        inj      = 1'b1;
        in_valid = 1'b1;
        check_frame(3'b110, 1'b0, 1'b1, 1'b0, 1'b0, "f110inj");
        inj = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
